// File: rtl/uart_pkg.sv
// Shared constants, RX state encoding and divider arithmetic for the UART front ends.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam logic [3:0] SAMP_A   = 4'd6;
    localparam logic [3:0] SAMP_B   = 4'd7;
    localparam logic [3:0] SAMP_C   = 4'd8;
    localparam logic [3:0] SAMP_DEC = 4'd8;
    localparam logic [3:0] SAMP_END = 4'd15;

    // Clamped to 1 so an over-fast baud setting still yields a legal divider.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int q;
        q = clk_freq / (baud * os);
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick divider; hold clears and freezes the count so timing restarts on release.
module uart_tick_gen #(
    parameter int DIV = 4
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_cnt_q, div_cnt_d;

    assign tick = !hold && (div_cnt_q == W'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + W'(1);
        if (hold || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 oversampling UART receiver with stretched valid/framing-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (default: single mid-bit sample).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, divider held, waiting for rx_s low
//   ST_START | validating start bit, false start returns to IDLE
//   ST_DATA  | shifting 8 data bits LSB first
//   ST_STOP  | checking stop bit, delivers byte or flags framing error
//   ST_BREAK | line stuck low after framing error, wait for high
module uart_rx_fsm #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_ferr,
    output logic       rx_busy
);
    import uart_pkg::*;

    localparam int DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int STRETCH = DIV * OVERSAMPLE;
    localparam int SW      = $clog2(STRETCH + 1);

    logic          sync1_q, rx_s_q;
    rx_state_e     state_q, state_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          status_q, ferr_q, busy_q;
    logic [SW-1:0] str_cnt_q;
    logic          samp7_q;
    logic          tick, hold, dec, bit_val, start_ok, start_err;

    assign hold = (state_q == ST_IDLE) || (state_q == ST_BREAK);
    assign dec  = tick && (s_cnt_q == SAMP_DEC);

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .sys_clk (sys_clk),
        .reset   (reset),
        .hold    (hold),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp6_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            samp6_q <= 1'b1;
        end else if (tick && (s_cnt_q == SAMP_A)) begin
            samp6_q <= rx_s_q;
        end
    end

    // The third vote is the live synchronised line on the decision tick.
    assign bit_val = (samp6_q & samp7_q) | (samp6_q & rx_s_q) | (samp7_q & rx_s_q);
`else
    assign bit_val = samp7_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            samp7_q <= 1'b1;
        end else if (tick && (s_cnt_q == SAMP_B)) begin
            samp7_q <= rx_s_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        start_ok  = 1'b0;
        start_err = 1'b0;
        if (tick) begin
            s_cnt_d = s_cnt_q + 4'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end
            ST_START: begin
                if (dec) begin
                    if (bit_val) begin
                        state_d = ST_IDLE;
                    end
                end else if (tick && (s_cnt_q == SAMP_END)) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (dec) begin
                    shreg_d[bit_idx_q] = bit_val;
                end
                if (tick && (s_cnt_q == SAMP_END)) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit gives back-to-back frames half a bit of slack.
                if (dec) begin
                    if (bit_val) begin
                        data_d   = shreg_q;
                        start_ok = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        start_err = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s_cnt_q   <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // One shared down-counter suffices: a new frame cannot finish inside a stretch.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            status_q  <= 1'b0;
            ferr_q    <= 1'b0;
            str_cnt_q <= '0;
        end else if (start_ok || start_err) begin
            status_q  <= start_ok;
            ferr_q    <= start_err;
            str_cnt_q <= SW'(STRETCH - 1);
        end else if (status_q || ferr_q) begin
            if (str_cnt_q == '0) begin
                status_q <= 1'b0;
                ferr_q   <= 1'b0;
            end else begin
                str_cnt_q <= str_cnt_q - SW'(1);
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_status = status_q;
    assign rx_ferr   = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm at DIV=4 (64-cycle bit period), scoreboard on strobes.
module tb_uart_rx_fsm;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BITP     = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status, rx_ferr, rx_busy;

    always #5 clk = ~clk;

    uart_rx_fsm #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sys_clk   (clk),
        .reset     (rst),
        .uart_rx   (rx_line),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .rx_ferr   (rx_ferr),
        .rx_busy   (rx_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        int         gap;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[5];

    logic [7:0] last_good = 8'h00;
    int fall_cyc = 0;
    int rise_cyc = 0;

    task automatic push_exp(input bit ferr, input logic [7:0] d);
        exp_t e;
        e.ferr = ferr;
        e.data = d;
        sb.push_back(e);
        if (!ferr) last_good = d;
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame (start, 8 data LSB first, stop) from a negedge; optional
    // one-tick inversion centred on the s_cnt==7 sample of data bit 2.
    task automatic send(input logic [7:0] d, input logic stop, input bit glitch, input int ncyc);
        logic [9:0] fr;
        logic v;
        fr = {stop, d, 1'b0};
        fall_cyc = cyc;
        for (int c = 0; c < ncyc; c++) begin
            v = fr[c / BITP];
            if (glitch && c >= 223 && c <= 226) v = ~v;
            rx_line = v;
            if (c == 320) check("busy_mid_frame", rx_busy, 1);
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit ev, prev;
        int wid;
        prev = 1'b0;
        wid  = 0;
        forever begin
            @(posedge clk);
            #1;
            ev = (rx_status === 1'b1) || (rx_ferr === 1'b1);
            if (ev && !prev) begin
                rise_cyc = cyc;
                wid = 0;
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {30'd0, rx_ferr, rx_status}, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_ferr", rx_ferr, e.ferr);
                    check("strobe_status", rx_status, !e.ferr);
                    check(e.ferr ? "rx_data_kept_on_ferr" : "rx_data", rx_data, e.data);
                end
            end
            if (ev) wid++;
            if (!ev && prev) check("strobe_width", wid, BITP);
            prev = ev;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vecs[0] = '{d: 8'h00, gap: 0,   exp: 8'h00};
        vecs[1] = '{d: 8'hFF, gap: 100, exp: 8'hFF};
        vecs[2] = '{d: 8'h5A, gap: 0,   exp: 8'h5A};
        vecs[3] = '{d: 8'h01, gap: 30,  exp: 8'h01};
        vecs[4] = '{d: 8'h80, gap: 100, exp: 8'h80};

        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_status", rx_status, 0);
        check("reset_rx_ferr", rx_ferr, 0);
        check("reset_rx_busy", rx_busy, 0);
        rst = 1'b0;
        idle(10);

        push_exp(0, 8'hA5);
        send(8'hA5, 1'b1, 0, 10 * BITP);
        idle(100);
        check("latency_a5", rise_cyc - fall_cyc, 2 + 153 * 4 + 1);
        check("busy_after_a5", rx_busy, 0);

        for (int i = 0; i < 5; i++) begin
            push_exp(0, vecs[i].exp);
            send(vecs[i].d, 1'b1, 0, 10 * BITP);
            check("vec_rx_data_end", rx_data, vecs[i].exp);
            idle(vecs[i].gap);
        end

        rx_line = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_enters_start", rx_busy, 1);
        idle(200);
        check("glitch_busy", rx_busy, 0);
        check("glitch_rx_data", rx_data, last_good);

        push_exp(1, last_good);
        send(8'h5A, 1'b0, 0, 10 * BITP);
        rx_line = 1'b0;
        repeat (500) @(negedge clk);
        check("break_busy", rx_busy, 1);
        idle(100);
        check("after_break_busy", rx_busy, 0);
        check("after_break_rx_data", rx_data, last_good);
        push_exp(0, 8'h3C);
        send(8'h3C, 1'b1, 0, 10 * BITP);
        idle(100);

        send(8'h81, 1'b1, 0, 4 * BITP + 32);
        rx_line = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_status", rx_status, 0);
        check("midreset_rx_ferr", rx_ferr, 0);
        check("midreset_rx_busy", rx_busy, 0);
        rst = 1'b0;
        last_good = 8'h00;
        idle(700);
        check("midreset_no_delivery", rx_data, last_good);
        push_exp(0, 8'h42);
        send(8'h42, 1'b1, 0, 10 * BITP);
        idle(100);

`ifdef UART_RX_MAJORITY_EN
        push_exp(0, 8'h00);
`else
        push_exp(0, 8'h04);
`endif
        send(8'h00, 1'b1, 1, 10 * BITP);
        idle(100);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Oversampling UART receive front end that sits directly upstream of the memory-mapped UART register block. It synchronises the asynchronous `uart_rx` line, detects and validates start bits, shifts in 8N1 frames LSB first, and hands each completed byte to the register block as `rx_data` plus a stretched `rx_status` strobe. The strobe is wide enough for the slower `cpu_clk` domain to sample. The block runs entirely on `sys_clk` and replaces the separate baud-generator clock with an internal tick enable.

## Interface
- `CLK_FREQ`, 100_000_000 — `sys_clk` frequency in Hz.
- `BAUD`, 9600 — line bit rate.
- `OVERSAMPLE`, 16 — ticks per bit; fixed at 16, parameter kept for the divider arithmetic.
- `sys_clk` input 1 — sole clock.
- `reset` input 1 — synchronous, active-high.
- `uart_rx` input 1 — asynchronous serial line; idles high.
- `rx_data` output 8 — last correctly framed byte.
- `rx_status` output 1 — byte-valid strobe, stretched as described under Timing.
- `rx_ferr` output 1 — framing-error strobe (stop bit sampled 0), same width as `rx_status`.
- `rx_busy` output 1 — high in every state except IDLE.

## Operation
- **Synchroniser:** 2-flop chain on `uart_rx`, reset value 1; the FSM sees only the synchronised value `rx_s`.
- **Tick generator:**
  - `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)` (integer division, must be ≥1).
  - `div_cnt` counts 0..DIV-1; `tick` is high for one cycle when `div_cnt == DIV-1`.
  - `div_cnt` is held at 0 in IDLE and BREAK, so bit timing aligns to the detected start edge.
- **Bit counter:** `s_cnt` (4 bit) increments on each tick and wraps 15→0, giving one bit period per 16 ticks.
- **Sampling:** samples are captured on ticks where `s_cnt` equals 6, 7 or 8. The bit value is decided on the tick where `s_cnt == 8`.
- **States:**
  - IDLE: when `rx_s == 0`, go to START and clear `s_cnt` and `div_cnt`.
  - START: at the decision point, if the bit value is 1 (false start) go to IDLE. Otherwise continue; on the tick with `s_cnt == 15`, go to DATA with `bit_idx = 0`.
  - DATA: at the decision point, shift the bit into `shreg[bit_idx]` (LSB first). On the tick with `s_cnt == 15`, increment `bit_idx`; after bit 7, go to STOP.
  - STOP: at the decision point:
    - value 1: `rx_data <= shreg`, start the `rx_status` stretch, go to IDLE. IDLE is entered half a bit early, allowing back-to-back frames.
    - value 0: start the `rx_ferr` stretch, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a break condition re-triggering START every bit.
- **Reset:** applies at any point, including mid-frame. It forces IDLE and clears `s_cnt`, `div_cnt`, `bit_idx`, `shreg`, `rx_data` (0x00), `rx_status`, `rx_ferr` and `rx_busy` (all 0). The synchroniser resets to 1. No partial byte is ever delivered.

## Timing
- `rx_status` and `rx_ferr` go high the cycle after the STOP decision tick and stay high for exactly `DIV*OVERSAMPLE` `sys_clk` cycles (one bit period).
- The stretch is 10416 cycles at the defaults, which exceeds any `cpu_clk` period.
- A new frame cannot complete inside a stretch, so stretches never overlap. `rx_data` is stable for the whole stretch and beyond.
- **Latency:**
  - Synchroniser: 2 cycles from the `uart_rx` fall to the IDLE→START transition.
  - Frame: the STOP decision tick is tick number 16 + 128 + 9 = 153 after START entry. That is `153*DIV` cycles, measured from the START-entry cycle to the decision cycle.
- `rx_busy` is registered, asserting the cycle after IDLE is exited and deasserting the cycle IDLE is re-entered.

## Configuration
- `UART_RX_MAJORITY_EN` defined: bit value is the 2-of-3 majority of the samples at `s_cnt` 6, 7 and 8.
- `UART_RX_MAJORITY_EN` undefined: bit value is the single sample at `s_cnt == 7`, and the 6/8 sample flops are not built.
- The decision point (`s_cnt == 8`) is identical in both builds.

## Structure
- **Package `uart_pkg`:**
  - `OVERSAMPLE` constant.
  - RX state enum: IDLE, START, DATA, STOP, BREAK.
  - Sample-index constants 6/7/8 and the decision index 8.
  - `DIV` computation as a constant function.
- **Sub-module `uart_tick_gen`:** divider producing `tick`, with a `hold` input that clears and freezes it. It is reusable by a future TX front end.

## Test plan
All scenarios use `CLK_FREQ=6_400_000`, `BAUD=100_000`, giving DIV=4 and a bit period of 64 cycles.
- **Single frame:** send 0xA5 in 8N1 → `rx_data` = 0xA5, `rx_status` high for exactly 64 cycles, `rx_ferr` = 0, and the first `rx_status` cycle is 2 + 153×4 + 1 cycles after the start edge.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap → two `rx_status` pulses, `rx_data` 0x00 then 0xFF, no lost frame.
- **Glitch rejection:** a 20-cycle low glitch on an idle line → returns to IDLE, no strobes, `rx_data` unchanged.
- **Framing error and break:** a frame with stop bit 0 followed by the line held low for 500 cycles → one `rx_ferr` pulse (64 cycles), `rx_data` unchanged. The next valid frame 0x3C is received correctly once the line returns high.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 3 of 0x81 → all outputs 0, no `rx_status` for that frame; the next frame 0x42 is received correctly.
- **Majority build only:** with `UART_RX_MAJORITY_EN` defined, a single-tick inversion at `s_cnt == 7` of bit 2 in 0x00 → `rx_data` = 0x00. In the undefined build the same stimulus yields 0x04.
